// File: rtl/plan_sequencer.sv
// plan_sequencer -- control sequencer for a level-synchronous path search engine.
//
// A search runs a forward sweep over the edge RAM, once per level, until the
// engine reports the target point was reached (end_hit). It then runs backward
// sweeps, one per level, each ended by the engine finding the back-pointing
// edge (step_done), down to level 0, and reports the hop count.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   start, abort      begin a search (sampled in IDLE only) / cancel a running one
//   start_point       source point index
//   end_point         target point index
//   max_level         level limit, 0 selects MAX_LEVEL_DEF
//   end_hit           engine: target activated during forward sweep
//   step_done         engine: backward edge found at current level
//   state             phase code IDLE=0 INIT=1 FWD=2 BWD=3 OUT=4 ERR=7
//   ram_addr          edge-RAM read address
//   ram_rd_en         edge-RAM read enable (FWD and BWD)
//   level             current search level
//   busy              high outside IDLE
//   done, error       one-cycle completion / failure pulses
//   err_code          0 none, 1 unreachable, 2 backtrack fail, 3 bad request
//   path_len          hop count of the last successful search
module plan_sequencer #(
   parameter int N_EDGES       = 1034,
   parameter int N_POINTS      = 66,
   parameter int MAX_LEVEL_DEF = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  start_point,
   input  logic [7:0]  end_point,
   input  logic [3:0]  max_level,
   input  logic        end_hit,
   input  logic        step_done,
   output logic [2:0]  state,
   output logic [10:0] ram_addr,
   output logic        ram_rd_en,
   output logic [3:0]  level,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [3:0]  path_len
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      FWD  = 3'd2,
      BWD  = 3'd3,
      OUTP = 3'd4,
      ERR  = 3'd7
   } phase_t;

   localparam logic [10:0] LastAddr = 11'(N_EDGES - 1);
   localparam logic [3:0]  DefLimit = 4'(MAX_LEVEL_DEF);

   phase_t      phaseQ, phaseD;
   logic [10:0] addrQ, addrD;
   logic [3:0]  levelQ, levelD;
   logic [3:0]  limitQ, limitD;
   logic [3:0]  hitLevelQ, hitLevelD;
   logic [1:0]  errCodeQ, errCodeD;
   logic [3:0]  pathLenQ, pathLenD;

   logic [3:0]  effLimit;
   logic        badRequest;
   logic        wrapHitsLimit;

   assign effLimit   = (max_level == 4'd0) ? DefLimit : max_level;
   assign badRequest = (int'(start_point) >= N_POINTS) ||
                       (int'(end_point) >= N_POINTS) ||
                       (start_point == end_point);
   // Level after a wrap compared in 5 bits so level 15 + 1 cannot alias to 0.
   assign wrapHitsLimit = ({1'b0, levelQ} + 5'd1) >= {1'b0, limitQ};

   always_ff @(posedge CLK) begin
      if (RST) begin
         phaseQ   <= IDLE;
         addrQ    <= '0;
         levelQ   <= '0;
         errCodeQ <= '0;
         pathLenQ <= '0;
      end else begin
         phaseQ   <= phaseD;
         addrQ    <= addrD;
         levelQ   <= levelD;
         errCodeQ <= errCodeD;
         pathLenQ <= pathLenD;
      end
   end

   // Search context only matters between an accepted start and the end of
   // that search, so it carries no reset.
   always_ff @(posedge CLK) begin
      limitQ    <= limitD;
      hitLevelQ <= hitLevelD;
   end

   always_comb begin
      phaseD    = phaseQ;
      addrD     = addrQ;
      levelD    = levelQ;
      limitD    = limitQ;
      hitLevelD = hitLevelQ;
      errCodeD  = errCodeQ;
      pathLenD  = pathLenQ;

      if (abort && (phaseQ != IDLE)) begin
         // Cancel silently: result registers keep whatever they hold.
         phaseD = IDLE;
      end else begin
         case (phaseQ)
            IDLE: begin
               if (start) begin
                  errCodeD = 2'd0;
                  pathLenD = 4'd0;
                  if (badRequest) begin
                     errCodeD = 2'd3;
                     phaseD   = ERR;
                  end else begin
                     limitD = effLimit;
                     addrD  = '0;
                     levelD = '0;
                     phaseD = INIT;
                  end
               end
            end
            INIT: begin
               addrD  = '0;
               levelD = '0;
               phaseD = FWD;
            end
            FWD: begin
               // end_hit wins over both the wrap and the limit check.
               if (end_hit) begin
                  hitLevelD = levelQ;
                  addrD     = '0;
                  phaseD    = BWD;
               end else if (addrQ == LastAddr) begin
                  if (wrapHitsLimit) begin
                     errCodeD = 2'd1;
                     phaseD   = ERR;
                  end else begin
                     addrD  = '0;
                     levelD = levelQ + 4'd1;
                  end
               end else begin
                  addrD = addrQ + 11'd1;
               end
            end
            BWD: begin
               if (step_done) begin
                  if (levelQ != 4'd0) begin
                     levelD = levelQ - 4'd1;
                     addrD  = '0;
                  end else begin
                     // Result published on entry so it is valid alongside done.
                     pathLenD = hitLevelQ + 4'd1;
                     phaseD   = OUTP;
                  end
               end else if (addrQ == LastAddr) begin
                  errCodeD = 2'd2;
                  phaseD   = ERR;
               end else begin
                  addrD = addrQ + 11'd1;
               end
            end
            OUTP:    phaseD = IDLE;
            ERR:     phaseD = IDLE;
            default: phaseD = IDLE;
         endcase
      end
   end

   assign state     = phaseQ;
   assign ram_addr  = addrQ;
   assign level     = levelQ;
   assign ram_rd_en = (phaseQ == FWD) || (phaseQ == BWD);
   assign busy      = (phaseQ != IDLE);
   assign done      = (phaseQ == OUTP);
   assign error     = (phaseQ == ERR);
   assign err_code  = errCodeQ;
   assign path_len  = pathLenQ;

endmodule

// File: doc/plan_sequencer.md
PLAN_SEQUENCER -- requirements
Module: plan_sequencer

Interface
REQ-001 Parameter N_EDGES, default 1034: number of edge-RAM entries; one sweep covers addresses 0..N_EDGES-1.
REQ-002 Parameter N_POINTS, default 66: number of graph points; valid point indices are 0..N_POINTS-1.
REQ-003 Parameter MAX_LEVEL_DEF, default 10: level limit used when max_level input is 0.
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-007 abort  in  1  cancels any running search.
REQ-008 start_point  in  8  search source point.
REQ-009 end_point  in  8  search target point.
REQ-010 max_level  in  4  level limit; 0 selects MAX_LEVEL_DEF.
REQ-011 end_hit  in  1  engine flag: target point activated during forward sweep.
REQ-012 step_done  in  1  engine flag: backward edge found at current level.
REQ-013 state  out  3  engine phase code: IDLE=0, INIT=1, FWD=2, BWD=3, OUT=4, ERR=7.
REQ-014 ram_addr  out  11  edge-RAM read address.
REQ-015 ram_rd_en  out  1  high in FWD and BWD only.
REQ-016 level  out  4  current search level.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse on successful completion.
REQ-019 error  out  1  one-cycle pulse on failure.
REQ-020 err_code  out  2  failure cause: 0 none, 1 unreachable, 2 backtrack fail, 3 bad request; held until the next accepted start.
REQ-021 path_len  out  4  hop count of the last successful search; held until the next accepted start.

Function
REQ-022 IDLE: on start=1, the block SHALL go to ERR with code 3 if start_point>=N_POINTS, end_point>=N_POINTS, or start_point==end_point; otherwise it SHALL go to INIT.
REQ-023 On an accepted start, the block SHALL latch start_point, end_point and the effective limit L (max_level, or MAX_LEVEL_DEF if 0), and clear err_code and path_len.
REQ-024 INIT SHALL last exactly one cycle, set ram_addr=0 and level=0, then go to FWD.
REQ-025 FWD: ram_addr SHALL increment by 1 every cycle; at N_EDGES-1 it SHALL wrap to 0 and level SHALL increment.
REQ-026 FWD: if a wrap would make level>=L, the block SHALL go to ERR with code 1.
REQ-027 FWD: on end_hit=1, the block SHALL latch hit_level=level, go to BWD with ram_addr=0, and keep level unchanged.
REQ-028 end_hit coinciding with the wrap address SHALL take priority over the wrap and over the code-1 check.
REQ-029 BWD: ram_addr SHALL increment each cycle. On step_done=1 with level>0, level SHALL decrement and ram_addr SHALL reset to 0. On step_done=1 with level==0, the block SHALL go to OUT.
REQ-030 BWD: a full sweep ending at N_EDGES-1 without step_done SHALL go to ERR with code 2; step_done on that same cycle SHALL take priority.
REQ-031 OUT SHALL last one cycle, set path_len=hit_level+1, pulse done, then go to IDLE.
REQ-032 ERR SHALL last one cycle, pulse error, then go to IDLE.
REQ-033 abort=1 in any state except IDLE SHALL force IDLE on the next cycle with no done or error pulse; err_code and path_len SHALL be unchanged.
REQ-034 start while busy SHALL be ignored. end_hit outside FWD and step_done outside BWD SHALL be ignored.
REQ-035 ram_addr and level SHALL hold their values in IDLE, OUT and ERR.

Reset
REQ-036 RST=1 SHALL, on the next edge, set state=IDLE(0) and ram_addr=0, level=0, ram_rd_en=0, busy=0, done=0, error=0, err_code=0, path_len=0. RST overrides every other input, including mid-search.

Verification
REQ-037 N_EDGES=8, start=1, start 0, end 5, end_hit at FWD level 1 address 3, then step_done once per level -> BWD entered with level=1; done pulses; path_len=2; state sequence 1,2,3,4,0.
REQ-038 end_point=66 with start=1 -> state 7 for one cycle; error pulses; err_code=3; no INIT.
REQ-039 max_level=2, N_EDGES=8, end_hit never asserted -> ERR after 16 FWD cycles; err_code=1.
REQ-040 In BWD, step_done never asserted for 8 cycles -> err_code=2. Separately, step_done on address 7 -> no error; level decrements.
REQ-041 abort during FWD -> IDLE next cycle; no done or error; prior path_len retained. RST mid-BWD -> all outputs at reset values next cycle.
